// File: rtl/cool_reg_spill.sv
// Cool register file context save/restore sequencer.
// Walks every accumulator between the file and data memory.
module cool_reg_spill #(
  parameter int WIDTH = 16,
  parameter int ID_W  = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Dir,
  input  logic [WIDTH-1:0] BaseAddr,
  input  logic [ID_W-1:0]  CurID,
  input  logic [WIDTH-1:0] CoolData,
  output logic [ID_W-1:0]  CrAddr,
  output logic             SetID,
  output logic             CRW,
  output logic [WIDTH-1:0] CrDataOut,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] MemWrData,
  output logic             MemWrite,
  input  logic [WIDTH-1:0] MemRdData,
  output logic             Busy,
  output logic             Done
);

  localparam int NUM_REGS = 2 ** ID_W;
  localparam logic [ID_W-1:0] LAST =
    ID_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    S_SEL,
    S_WR,
    R_RD,
    R_WR,
    RESEL,
    DONE
  } state_t;

  state_t           state;
  state_t           stateNxt;
  logic [ID_W-1:0]  idx;
  logic [ID_W-1:0]  idxNxt;
  logic [ID_W-1:0]  curId;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] wordAddr;
  logic             accept;

  // Direction is captured by the state chosen on accept
  assign accept   = (state == IDLE) && Start;
  assign wordAddr = base + WIDTH'(idx);

  // State, index and the operands latched at accept
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      idx   <= '0;
      base  <= '0;
      curId <= '0;
    end else begin
      state <= stateNxt;
      idx   <= idxNxt;
      if (accept) begin
        base  <= BaseAddr;
        curId <= CurID;
      end
    end
  end

  // Next state and Moore-decoded strobes
  always_comb begin
    stateNxt  = state;
    idxNxt    = idx;
    CrAddr    = '0;
    SetID     = 1'b0;
    CRW       = 1'b0;
    CrDataOut = '0;
    MemAddr   = '0;
    MemWrData = '0;
    MemWrite  = 1'b0;
    Busy      = 1'b1;
    Done      = 1'b0;
    unique case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Start) begin
          idxNxt   = '0;
          stateNxt = Dir ? R_RD : S_SEL;
        end
      end
      S_SEL: begin
        SetID    = 1'b1;
        CrAddr   = idx;
        stateNxt = S_WR;
      end
      S_WR: begin
        MemWrite  = 1'b1;
        MemAddr   = wordAddr;
        MemWrData = CoolData;
        if (idx == LAST) begin
          stateNxt = RESEL;
        end else begin
          idxNxt   = idx + 1'b1;
          stateNxt = S_SEL;
        end
      end
      R_RD: begin
        MemAddr  = wordAddr;
        stateNxt = R_WR;
      end
      R_WR: begin
        SetID     = 1'b1;
        CRW       = 1'b1;
        CrAddr    = idx;
        CrDataOut = MemRdData;
        MemAddr   = wordAddr;
        if (idx == LAST) begin
          stateNxt = RESEL;
        end else begin
          idxNxt   = idx + 1'b1;
          stateNxt = R_RD;
        end
      end
      RESEL: begin
        SetID    = 1'b1;
        CrAddr   = curId;
        stateNxt = DONE;
      end
      DONE: begin
        Done     = 1'b1;
        stateNxt = IDLE;
      end
      default: begin
        Busy     = 1'b0;
        stateNxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cool_reg_spill.sv
// Bench for cool_reg_spill with file/memory models
// and a scoreboard of expected memory and register writes.
module tb_cool_reg_spill;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Dir;
  logic [15:0] BaseAddr;
  logic [1:0]  CurID;
  logic [15:0] CoolData;
  logic [1:0]  CrAddr;
  logic        SetID;
  logic        CRW;
  logic [15:0] CrDataOut;
  logic [15:0] MemAddr;
  logic [15:0] MemWrData;
  logic        MemWrite;
  logic [15:0] MemRdData;
  logic        Busy;
  logic        Done;

  int nCmp = 0;
  int nErr = 0;
  int cyc = 0;
  int wrCnt = 0;
  int crwCnt = 0;
  int doneCnt = 0;
  int doneCyc[$];
  logic [31:0] wq[$];
  logic [31:0] rq[$];

  logic [15:0] mem [0:65535];
  logic [15:0] regs [0:3];
  logic [1:0]  sel;
  logic        ldMem, ldReg, ldSel;
  logic [15:0] ldAddr, ldVal;

  cool_reg_spill #(.WIDTH(16), .ID_W(2)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start),
    .Dir(Dir), .BaseAddr(BaseAddr), .CurID(CurID),
    .CoolData(CoolData), .CrAddr(CrAddr),
    .SetID(SetID), .CRW(CRW),
    .CrDataOut(CrDataOut), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemWrite(MemWrite),
    .MemRdData(MemRdData), .Busy(Busy),
    .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // Register file and memory models
  assign CoolData = regs[sel];
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (ldMem) mem[ldAddr] <= ldVal;
    else if (MemWrite) mem[MemAddr] <= MemWrData;
    MemRdData <= mem[MemAddr];
    if (ldReg) regs[ldAddr[1:0]] <= ldVal;
    if (ldSel) sel <= ldAddr[1:0];
    if (SetID) sel <= CrAddr;
    if (CRW) regs[CrAddr] <= CrDataOut;
  end

  // Scoreboard: pop expected writes as strobes appear
  always @(negedge CLK) begin
    logic [31:0] e;
    if (!Reset) begin
      if (MemWrite) begin
        wrCnt++;
        if (wq.size() == 0) chk("extra_wr", 1, 0);
        else begin
          e = wq.pop_front();
          chk("wr_addr", MemAddr, e[31:16]);
          chk("wr_data", MemWrData, e[15:0]);
        end
      end
      if (CRW) begin
        crwCnt++;
        if (rq.size() == 0) chk("extra_crw", 1, 0);
        else begin
          e = rq.pop_front();
          chk("crw_id", CrAddr, e[17:16]);
          chk("crw_data", CrDataOut, e[15:0]);
        end
      end
      if (Done) begin
        doneCnt++;
        doneCyc.push_back(cyc);
      end
    end
  end

  task automatic load(input int kind,
                      input logic [15:0] a,
                      input logic [15:0] v);
    @(negedge CLK);
    ldAddr = a;
    ldVal = v;
    ldMem = (kind == 0);
    ldReg = (kind == 1);
    ldSel = (kind == 2);
    @(negedge CLK);
    ldMem = 0; ldReg = 0; ldSel = 0;
  endtask

  task automatic pushSave(input logic [15:0] b);
    for (int i = 0; i < 4; i++)
      wq.push_back({b + 16'(i), regs[i]});
  endtask

  task automatic runOp(input logic d,
                       input logic [15:0] b,
                       input logic [1:0] id,
                       input int pulseAt);
    int lat;
    int w0, r0, d0;
    w0 = wrCnt; r0 = crwCnt; d0 = doneCnt;
    @(negedge CLK);
    Start = 1; Dir = d; BaseAddr = b; CurID = id;
    @(negedge CLK);
    Start = 0;
    lat = 1;
    chk("busy_n1", Busy, 1);
    while (!Done && lat < 30) begin
      @(negedge CLK);
      lat++;
      if (lat == pulseAt) begin
        Start = 1; BaseAddr = 16'h0300;
        CurID = ~id;
      end else Start = 0;
    end
    chk("latency", lat, 10);
    @(negedge CLK);
    chk("idle", {Busy, Done}, 0);
    chk("n_wr", wrCnt - w0, d ? 0 : 4);
    chk("n_crw", crwCnt - r0, d ? 4 : 0);
    chk("n_done", doneCnt - d0, 1);
    chk("wq_left", wq.size(), 0);
    chk("rq_left", rq.size(), 0);
  endtask

  initial begin
    int w0, k, n;
    Reset = 1; Start = 0; Dir = 0;
    BaseAddr = 0; CurID = 0;
    ldMem = 0; ldReg = 0; ldSel = 0;
    ldAddr = 0; ldVal = 0;
    #12;
    chk("rst_out",
        {CrAddr, SetID, CRW, CrDataOut, MemAddr,
         MemWrData, MemWrite, Busy, Done}, 0);
    @(negedge CLK);
    Reset = 0;

    // Save with active id 2
    load(1, 0, 16'h1111);
    load(1, 1, 16'h2222);
    load(1, 2, 16'h3333);
    load(1, 3, 16'h4444);
    load(2, 2, 0);
    pushSave(16'h0100);
    runOp(0, 16'h0100, 2, 0);
    chk("save_cool", CoolData, 16'h3333);
    chk("mem_103", mem[16'h0103], 16'h4444);

    // Address wrap
    pushSave(16'hFFFE);
    runOp(0, 16'hFFFE, 3, 0);
    chk("wrap_cool", CoolData, 16'h4444);
    chk("mem_0001", mem[16'h0001], 16'h4444);

    // Start while busy is ignored
    pushSave(16'h0800);
    runOp(0, 16'h0800, 0, 3);
    chk("busy_cool", CoolData, 16'h1111);
    chk("mem_300", mem[16'h0300], 0);

    // Reset after the second write
    load(0, 16'h0502, 16'hDEAD);
    pushSave(16'h0500);
    w0 = wrCnt;
    @(negedge CLK);
    Start = 1; Dir = 0; BaseAddr = 16'h0500;
    CurID = 1;
    @(negedge CLK);
    Start = 0;
    for (int i = 0; i < 40 && wrCnt - w0 < 2; i++)
      @(posedge CLK);
    #1 Reset = 1;
    #1;
    chk("abort_out",
        {CrAddr, SetID, CRW, CrDataOut, MemAddr,
         MemWrData, MemWrite, Busy, Done}, 0);
    repeat (3) @(negedge CLK);
    Reset = 0;
    wq.delete();
    chk("abort_nwr", wrCnt - w0, 2);
    chk("abort_m1", mem[16'h0501], 16'h2222);
    chk("abort_m2", mem[16'h0502], 16'hDEAD);
    pushSave(16'h0600);
    runOp(0, 16'h0600, 1, 0);
    chk("post_m3", mem[16'h0603], 16'h4444);

    // Restore
    load(0, 16'h0200, 16'h000A);
    load(0, 16'h0201, 16'h000B);
    load(0, 16'h0202, 16'h000C);
    load(0, 16'h0203, 16'h000D);
    for (int i = 0; i < 4; i++)
      rq.push_back({14'(0), 2'(i), 16'(10 + i)});
    runOp(1, 16'h0200, 1, 0);
    chk("rst_cool", CoolData, 16'h000B);
    chk("reg0", regs[0], 16'h000A);
    chk("reg3", regs[3], 16'h000D);

    // Back-to-back with Start held high
    for (int j = 0; j < 3; j++) pushSave(16'h0700);
    w0 = wrCnt;
    n = doneCyc.size();
    k = 0;
    @(negedge CLK);
    Start = 1; Dir = 0; BaseAddr = 16'h0700;
    CurID = 0;
    for (int i = 0; i < 60 && k < 3; i++) begin
      @(negedge CLK);
      #1;
      if (Done) k++;
    end
    Start = 0;
    repeat (3) @(negedge CLK);
    chk("b2b_done", k, 3);
    chk("b2b_nwr", wrCnt - w0, 12);
    chk("b2b_wq", wq.size(), 0);
    if (doneCyc.size() >= n + 3) begin
      chk("b2b_gap1",
          doneCyc[n+1] - doneCyc[n], 11);
      chk("b2b_gap2",
          doneCyc[n+2] - doneCyc[n+1], 11);
    end else chk("b2b_cnt", doneCyc.size(), n + 3);
    chk("b2b_idle", Busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/cool_reg_spill.md
Name: cool_reg_spill

Overview:
Context save/restore sequencer for the cool register file. Save mode reads each cool accumulator in turn through the file's select/read port and stores it to data memory. Restore mode reads memory back and writes each accumulator through the file's select/write port. Used by the control unit on interrupt entry and return. It drives the same CrAddr/SetID/CRW/DataIn pins the datapath drives, through a mux owned by the control unit while Busy=1.

Parameters:
WIDTH, 16, data and memory address width
ID_W, 2, cool register index width; NUM_REGS = 2**ID_W (4)

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  request; sampled in IDLE only
Dir  in  1  0 = save (regs -> mem), 1 = restore (mem -> regs); latched with Start
BaseAddr  in  WIDTH  first memory word; latched with Start
CurID  in  ID_W  active accumulator index to reselect at the end; latched with Start
CoolData  in  WIDTH  cool register file read data (currently selected register)
CrAddr  out  ID_W  register index to the file
SetID  out  1  select strobe to the file
CRW  out  1  write strobe to the file
CrDataOut  out  WIDTH  write data to the file (DataIn pin)
MemAddr  out  WIDTH  memory address
MemWrData  out  WIDTH  memory write data
MemWrite  out  1  memory write strobe
MemRdData  in  WIDTH  memory read data, valid one cycle after MemAddr is presented
Busy  out  1  high from the cycle after Start is accepted until Done
Done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any time): state=IDLE, idx=0; all outputs 0. Reset mid-operation aborts at once, with no further strobes. Memory words or registers already written stay written. Reset wins over a simultaneous Start.
- Moore outputs decoded from registered state, idx, and the latched base, dir and id. Exception: MemWrData and CrDataOut pass CoolData and MemRdData straight through.
- File semantics relied on: SetID=1 at an edge makes CrAddr the active register. CoolData then shows it from the next cycle. CRW=1 at the same edge writes CrDataOut into the newly selected register.
- States: IDLE, S_SEL, S_WR, R_RD, R_WR, RESEL, DONE.
- IDLE: Busy=0. If Start=1, latch Dir, BaseAddr and CurID, set idx=0, and go to S_SEL if Dir=0 or R_RD if Dir=1.
- S_SEL: SetID=1, CrAddr=idx. Next state S_WR.
- S_WR: MemWrite=1, MemAddr=base+idx, MemWrData=CoolData. If idx==NUM_REGS-1 go to RESEL, else idx++ and go to S_SEL.
- R_RD: MemAddr=base+idx, MemWrite=0. Next state R_WR.
- R_WR: SetID=1, CRW=1, CrAddr=idx, CrDataOut=MemRdData, MemAddr holds base+idx. If idx==NUM_REGS-1 go to RESEL, else idx++ and go to R_RD.
- RESEL: SetID=1, CrAddr=latched CurID, CRW=0. Next state DONE.
- DONE: Done=1, Busy=1 for one cycle. Next state IDLE. A Start in the DONE cycle is ignored; a Start on the following cycle (IDLE) is accepted.
- Busy=1 in every non-IDLE state.
- Latency: Start accepted at edge N. Both modes take 2*NUM_REGS+2 = 10 cycles; Done is high in cycle N+10 and the block is back in IDLE at N+11.
- Address arithmetic: base+idx modulo 2^WIDTH. Base 0xFFFE wraps to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Start while Busy is ignored and never queued. Dir, BaseAddr and CurID changing mid-operation have no effect.
- CRW is never asserted in save mode. MemWrite is never asserted in restore mode.

Test Plan:
- Save: preload regs 0..3 = 0x1111, 0x2222, 0x3333, 0x4444 with active id 2. Start, Dir=0, Base=0x0100, CurID=2 -> MemWrite pulses at 0x0100..0x0103 with data 0x1111..0x4444. Done at cycle N+10, CoolData=0x3333 afterwards, CRW never high.
- Restore: memory 0x0200..0x0203 = 0xA, 0xB, 0xC, 0xD. Start, Dir=1, Base=0x0200, CurID=1 -> regs 0..3 read back 0xA..0xD. Final active register is 1 (CoolData=0xB). MemWrite never high.
- Wrap: save with Base=0xFFFE -> write addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 in that order.
- Start while busy: second Start pulse at cycle N+3 with Base=0x0300 -> ignored; exactly 4 writes, all at the original base, and a single Done.
- Reset mid-save: assert Reset after the second MemWrite -> all outputs 0 at once; only 2 memory words written. A new Start after release runs a full, correct save.
- Back-to-back: Start held high continuously -> operations restart one cycle after each Done, i.e. a new one is accepted every 11 cycles.
